ce_merge_arb: RTL and testbench
===============================

# ce_merge_arb

Synchronous two-input merge arbiter for the DDP Send/Ack token pipeline. Two upstream requesters, each with an active-low Send/Ack handshake and a data word, share one downstream C-element pipeline stage. The block selects one requester, drives the shared stage's Send/data, and returns Ack only to the winner. It runs alongside the C/CE stage chain wherever two token streams join.

## Interface
Parameters:
- DW, 16, data word width in bits
- TIMEOUT, 255, maximum SEND-state cycles before Err is set; 0 disables the watchdog

Ports:
- CLK  in  1  clock, all state on rising edge
- MR  in  1  master reset; synchronous, active-high
- Send_in0  in  1  requester 0 send, active-low, held low until Ack_out0 low
- Data_in0  in  DW  requester 0 data, valid while Send_in0 low
- Ack_out0  out  1  ack to requester 0, active-low
- Send_in1  in  1  requester 1 send, active-low
- Data_in1  in  DW  requester 1 data
- Ack_out1  out  1  ack to requester 1, active-low
- Send_out  out  1  send to shared stage, active-low
- Data_out  out  DW  data to shared stage, registered
- Ack_in  in  1  ack from shared stage, active-low
- Grant  out  1  index of the current or last winner
- Busy  out  1  high in any state other than IDLE
- Err  out  1  sticky watchdog flag, cleared only by MR

## Operation
- Four-phase active-low handshake on every port. Idle level of all Send and Ack lines is 1.
- FSM states:
  - IDLE: if any Send_in is 0, pick a winner, latch its Data_in into Data_out, latch its index into Grant, then go to SEND.
  - SEND: Send_out=0. When Ack_in==0 is sampled, go to ACK.
  - ACK: Send_out=1 and Ack_out[Grant]=0. When Send_in[Grant]==1 and Ack_in==1 are both sampled, go to REL.
  - REL: Ack_out[Grant]=1, update the priority pointer, then go to IDLE.
- Arbitration with both Send_in low in IDLE: the requester other than the last winner wins. The pointer resets to 1, so requester 0 wins first.
- Data_out changes only on the IDLE→SEND transition and is held otherwise.
- The loser's Send_in stays low and is serviced on a later pass. Its Ack_out stays 1 throughout.
- If the winner raises Send_in during SEND (protocol violation), the transfer still completes on the latched data.
- Watchdog:
  - An 8-bit saturating counter (width = clog2(TIMEOUT+1)) increments each SEND cycle and clears on leaving SEND.
  - Reaching TIMEOUT sets Err. The state does not change.

## Timing
- MR sampled high → on the next edge: state IDLE, Send_out=1, Ack_out0=Ack_out1=1, Data_out=0, Grant=0, pointer=1, Busy=0, Err=0, counter=0. This applies from any state, including mid-transfer.
- All outputs are registered.
- Send_in sampled low at edge N → Send_out=0 after edge N+1.
- Ack_in sampled low at edge M → Ack_out[Grant]=0 and Send_out=1 after edge M+1.
- Release of both Send_in[Grant] and Ack_in sampled at edge R → Ack_out=1 after edge R+1. The next grant can occur at edge R+2.
- Minimum of 4 cycles per token when the environment responds in zero cycles.
- MR has priority over every other event in the same cycle.

## Configuration
- CE_MERGE_ROUND_ROBIN_EN defined: alternating priority as described under Operation.
- CE_MERGE_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties. The pointer register is removed. Grant still reports the winner.

## Structure
- Package ce_hs_pkg holds:
  - the state enum (IDLE, SEND, ACK, REL)
  - the constants HS_IDLE=1'b1 and HS_ACTIVE=1'b0
- Sub-module ce_rr_pick: combinational two-way picker. Inputs are the request vector and the pointer; output is the winner index. It contains the compile-time variant selected by CE_MERGE_ROUND_ROBIN_EN.

## Test plan
- MR=1 for 3 cycles, then 0 → Send_out=1, Ack_out0=Ack_out1=1, Busy=0, Err=0, Data_out=0.
- Send_in0=0 with Data_in0=16'hA5A5; Ack_in follows Send_out after 1 cycle → Send_out low 1 cycle after the request, Data_out=A5A5, Ack_out0 low, Ack_out1 stays 1, back to IDLE after release.
- Send_in0 and Send_in1 low together, four tokens each (Data_in0=0x0000..3, Data_in1=0x1000..3) → Grant sequence 0,1,0,1,… with round-robin; 0,0,0,0,1,1,1,1 without the macro.
- Ack_in held high for 300 cycles with TIMEOUT=255 → Err=1 at SEND cycle 255 and stays 1 after the transfer completes.
- MR pulsed during the ACK state → all outputs return to idle values on the next edge; a subsequent request completes normally.
- Ack_in released before Send_in0 is released → the block remains in ACK until both are high, then Ack_out0 returns to 1.

Source files
------------

// File: rtl/ce_hs_pkg.sv
// Shared handshake definitions for the C-element merge arbiter.
package ce_hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    REL
  } hs_state_e;

  // Active-low Send/Ack signalling levels.
  localparam logic HS_IDLE   = 1'b1;
  localparam logic HS_ACTIVE = 1'b0;

  // Watchdog counter width; never narrower than one bit so a disabled watchdog still elaborates.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ce_rr_pick.sv
// Combinational two-way winner picker.
// CE_MERGE_ROUND_ROBIN_EN defined: on a tie the requester other than ptr wins.
// CE_MERGE_ROUND_ROBIN_EN undefined: requester 0 always wins a tie; ptr is ignored.
module ce_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner
);

`ifdef CE_MERGE_ROUND_ROBIN_EN
  // Alternate on a tie, otherwise take whichever requester is asking.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~ptr;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign winner     = req[1] & ~req[0];
`endif

endmodule

// File: rtl/ce_merge_arb.sv
// Two-input merge arbiter for the DDP Send/Ack token pipeline.
// Picks one active-low requester, forwards its latched word to the shared stage and returns
// Ack only to the winner. CE_MERGE_ROUND_ROBIN_EN selects alternating tie priority; without
// it requester 0 wins ties and the priority pointer register does not exist.
module ce_merge_arb
  import ce_hs_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic          Send_in0,
  input  logic [DW-1:0] Data_in0,
  output logic          Ack_out0,
  input  logic          Send_in1,
  input  logic [DW-1:0] Data_in1,
  output logic          Ack_out1,
  output logic          Send_out,
  output logic [DW-1:0] Data_out,
  input  logic          Ack_in,
  output logic          Grant,
  output logic          Busy,
  output logic          Err
);

  localparam int unsigned   CW     = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT);

  hs_state_e     state_q, state_d;
  logic [1:0]    req;
  logic          winner;
  logic          ptr;
  logic          send_win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] data_q;
  logic          grant_q;
  logic          send_q, ack0_q, ack1_q, busy_q;

  assign req      = {Send_in1 == HS_ACTIVE, Send_in0 == HS_ACTIVE};
  assign send_win = grant_q ? Send_in1 : Send_in0;

`ifdef CE_MERGE_ROUND_ROBIN_EN
  logic ptr_q;

  // Priority pointer remembers the last completed winner.
  always_ff @(posedge CLK) begin
    if (MR) begin
      ptr_q <= 1'b1;
    end else if (state_q == REL) begin
      ptr_q <= grant_q;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b1;
`endif

  ce_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  // Handshake sequencing: the winner's release and the stage's release must both be seen.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = SEND;
      SEND:    if (Ack_in == HS_ACTIVE) state_d = ACK;
      ACK:     if (send_win == HS_IDLE && Ack_in == HS_IDLE) state_d = REL;
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: saturating count of SEND cycles; hitting the limit latches Err.
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == SEND) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1'b1);
      if (TIMEOUT != 0 && cnt_d == CntMax) begin
        err_d = 1'b1;
      end
    end
  end

  // State and registered outputs; handshake lines follow the state one cycle later.
  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      grant_q <= 1'b0;
      send_q  <= HS_IDLE;
      ack0_q  <= HS_IDLE;
      ack1_q  <= HS_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      send_q  <= (state_q == SEND) ? HS_ACTIVE : HS_IDLE;
      ack0_q  <= (state_q == ACK && !grant_q) ? HS_ACTIVE : HS_IDLE;
      ack1_q  <= (state_q == ACK && grant_q) ? HS_ACTIVE : HS_IDLE;
      if (state_q == IDLE && |req) begin
        data_q  <= winner ? Data_in1 : Data_in0;
        grant_q <= winner;
      end
    end
  end

  assign Send_out = send_q;
  assign Ack_out0 = ack0_q;
  assign Ack_out1 = ack1_q;
  assign Data_out = data_q;
  assign Grant    = grant_q;
  assign Busy     = busy_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_ce_merge_arb.sv
// Self-checking bench for ce_merge_arb: directed handshake/timing cases plus randomized
// two-requester traffic checked by a scoreboard against an arbitration reference model.
module tb_ce_merge_arb;

  localparam int DW = 16;
`ifdef CE_MERGE_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          MR;
  logic          Send_in0, Send_in1, Ack_in;
  logic [DW-1:0] Data_in0, Data_in1;
  logic          Ack_out0, Ack_out1, Send_out, Grant, Busy, Err;
  logic [DW-1:0] Data_out;

  always #5 CLK = ~CLK;

  ce_merge_arb #(
    .DW      (DW),
    .TIMEOUT (255)
  ) dut (
    .CLK      (CLK),
    .MR       (MR),
    .Send_in0 (Send_in0),
    .Data_in0 (Data_in0),
    .Ack_out0 (Ack_out0),
    .Send_in1 (Send_in1),
    .Data_in1 (Data_in1),
    .Ack_out1 (Ack_out1),
    .Send_out (Send_out),
    .Data_out (Data_out),
    .Ack_in   (Ack_in),
    .Grant    (Grant),
    .Busy     (Busy),
    .Err      (Err)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          grant_log[$];
  logic          lw;          // last winner seen by the model
  logic [1:0]    req_snap;    // requests as sampled on the last rising edge

  always @(posedge CLK) req_snap <= {~Send_in1, ~Send_in0};

  initial begin
    #600000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int idx, input logic snd, input logic [DW-1:0] d);
    if (idx == 0) begin
      Send_in0 = snd;
      Data_in0 = d;
    end else begin
      Send_in1 = snd;
      Data_in1 = d;
    end
  endtask

  // Issue a token: the expected word goes into the scoreboard as the request is raised.
  task automatic issue(input int idx, input logic [DW-1:0] d);
    if (idx == 0) exp_q0.push_back(d);
    else exp_q1.push_back(d);
    drive(idx, 1'b0, d);
  endtask

  task automatic wait_ack(input int idx, input logic lvl, input string name);
    int t = 0;
    while (((idx == 0) ? Ack_out0 : Ack_out1) !== lvl && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    chk(name, (idx == 0) ? Ack_out0 : Ack_out1, lvl);
  endtask

  task automatic wait_send(input logic lvl, input string name);
    int t = 0;
    while (Send_out !== lvl && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    chk(name, Send_out, lvl);
  endtask

  task automatic requester(input int idx, input int n, input int base, input int gap,
                           input bit rnd);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(gap, 0)) @(negedge CLK);
      d = rnd ? DW'($urandom) : DW'(base + k);
      issue(idx, d);
      wait_ack(idx, 1'b0, "req_ack_low");
      repeat ($urandom_range(gap, 0)) @(negedge CLK);
      drive(idx, 1'b1, DW'($urandom));
      wait_ack(idx, 1'b1, "req_ack_high");
    end
  endtask

  task automatic responder(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      wait_send(1'b0, "resp_send_low");
      repeat ($urandom_range(gap, 0)) @(negedge CLK);
      Ack_in = 1'b0;
      wait_send(1'b1, "resp_send_high");
      repeat ($urandom_range(gap, 0)) @(negedge CLK);
      Ack_in = 1'b1;
    end
  endtask

  // Scoreboard monitor: on each new grant, predict the winner from the sampled requests and
  // pop that requester's expected word; while busy, the word must hold and the loser stays idle.
  task automatic monitor();
    logic          busy_prev = 1'b0;
    logic          in_xfer = 1'b0;
    logic          cur_w = 1'b0;
    logic          exp_w;
    logic [DW-1:0] cur_d = '0;
    forever begin
      @(negedge CLK);
      if (Busy !== 1'b1) begin
        in_xfer = 1'b0;
      end else if (!busy_prev) begin
        chk("grant_has_request", {31'd0, req_snap != 2'b00}, 1);
        exp_w = (req_snap == 2'b11) ? (RR ? ~lw : 1'b0) : req_snap[1];
        chk("grant", Grant, exp_w);
        chk("queue_nonempty", exp_w ? exp_q1.size() : exp_q0.size(), 0 + (exp_w ?
            (exp_q1.size() == 0 ? 1 : exp_q1.size()) : (exp_q0.size() == 0 ? 1 : exp_q0.size())));
        if (exp_w && exp_q1.size() != 0) cur_d = exp_q1.pop_front();
        else if (!exp_w && exp_q0.size() != 0) cur_d = exp_q0.pop_front();
        lw      = exp_w;
        cur_w   = exp_w;
        in_xfer = 1'b1;
        grant_log.push_back(Grant);
      end
      if (in_xfer) begin
        chk("data_out", Data_out, cur_d);
        chk("loser_ack_idle", cur_w ? Ack_out0 : Ack_out1, 1);
      end
      busy_prev = (Busy === 1'b1);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_send_out"}, Send_out, 1);
    chk({tag, "_ack_out0"}, Ack_out0, 1);
    chk({tag, "_ack_out1"}, Ack_out1, 1);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_err"}, Err, 0);
    chk({tag, "_data_out"}, Data_out, 0);
    chk({tag, "_grant"}, Grant, 0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    MR       = 1'b1;
    Send_in0 = 1'b1;
    Send_in1 = 1'b1;
    Ack_in   = 1'b1;
    repeat (cycles) @(negedge CLK);
    check_idle(tag);
    MR = 1'b0;
    lw = 1'b1;
  endtask

  initial begin
    MR       = 1'b1;
    Send_in0 = 1'b1;
    Send_in1 = 1'b1;
    Ack_in   = 1'b1;
    Data_in0 = '0;
    Data_in1 = '0;
    lw       = 1'b1;
    fork
      monitor();
    join_none

    // Reset state.
    do_reset(3, "reset");
    @(negedge CLK);

    // Single token with exact handshake latencies.
    issue(0, 16'hA5A5);
    @(negedge CLK);
    chk("t1_busy", Busy, 1);
    chk("t1_send_latency", Send_out, 1);
    @(negedge CLK);
    chk("t1_send_low", Send_out, 0);
    chk("t1_data", Data_out, 16'hA5A5);
    Ack_in = 1'b0;
    @(negedge CLK);
    chk("t1_ack_latency", Ack_out0, 1);
    @(negedge CLK);
    chk("t1_ack0_low", Ack_out0, 0);
    chk("t1_send_high", Send_out, 1);
    chk("t1_ack1_idle", Ack_out1, 1);
    Send_in0 = 1'b1;
    Ack_in   = 1'b1;
    @(negedge CLK);
    chk("t1_rel_ack_still_low", Ack_out0, 0);
    chk("t1_rel_busy", Busy, 1);
    @(negedge CLK);
    chk("t1_ack0_release", Ack_out0, 1);
    chk("t1_idle", Busy, 0);

    // Stage releases Ack before the requester releases Send: stay in ACK.
    @(negedge CLK);
    issue(0, 16'h5A5A);
    wait_send(1'b0, "t5_send_low");
    Ack_in = 1'b0;
    wait_ack(0, 1'b0, "t5_ack_low");
    Ack_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("t5_hold_ack", Ack_out0, 0);
      chk("t5_hold_busy", Busy, 1);
    end
    Send_in0 = 1'b1;
    @(negedge CLK);
    chk("t5_rel_ack", Ack_out0, 0);
    @(negedge CLK);
    chk("t5_ack_release", Ack_out0, 1);

    // Watchdog: stage never acks for 300 cycles.
    @(negedge CLK);
    issue(0, 16'h1234);
    @(negedge CLK);
    chk("t3_busy", Busy, 1);
    repeat (254) @(negedge CLK);
    chk("t3_err_before", Err, 0);
    @(negedge CLK);
    chk("t3_err_set", Err, 1);
    repeat (45) @(negedge CLK);
    Ack_in = 1'b0;
    wait_ack(0, 1'b0, "t3_ack_low");
    Send_in0 = 1'b1;
    Ack_in   = 1'b1;
    wait_ack(0, 1'b1, "t3_ack_high");
    @(negedge CLK);
    chk("t3_err_sticky", Err, 1);
    do_reset(1, "t3_clear");

    // Master reset in the middle of ACK, then a normal transfer.
    @(negedge CLK);
    issue(0, 16'hBEEF);
    wait_send(1'b0, "t4_send_low");
    Ack_in = 1'b0;
    wait_ack(0, 1'b0, "t4_ack_low");
    do_reset(1, "t4_mr");
    @(negedge CLK);
    fork
      requester(0, 1, 16'h0F0F, 0, 1'b0);
      responder(1, 0);
    join

    // Both requesters hold four tokens each from a fresh pointer.
    do_reset(3, "t2_reset");
    @(negedge CLK);
    grant_log.delete();
    fork
      requester(0, 4, 16'h0000, 0, 1'b0);
      requester(1, 4, 16'h1000, 0, 1'b0);
      responder(8, 0);
    join
    chk("t2_grant_count", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      chk("t2_grant_seq", grant_log[k], RR ? k[0] : (k >= 4));
    end

    // Randomized traffic.
    repeat (2) @(negedge CLK);
    fork
      requester(0, 12, 0, 3, 1'b1);
      requester(1, 12, 0, 3, 1'b1);
      responder(24, 2);
    join

    repeat (3) @(negedge CLK);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    chk("end_idle", Busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
